branch_predict_unit: RTL
========================

Name: branch_predict_unit

Overview:
- Fetch-stage dynamic branch predictor: a branch target buffer (BTB) plus a table of 2-bit saturating counters.
- Fetch side: looks up the fetch PC and supplies the next-PC prediction.
- Decode side: resolves the prediction against the branch outcome computed in Decode. Drives predict_miss_o into the hazard unit and the recovery PC into the PC mux.
- Trains its tables on every resolved branch.

Parameters:
- ENTRIES, 64, number of BTB/counter entries (power of two); INDEX_W = log2(ENTRIES).
- TAG_W, 8, PC tag bits stored per BTB entry, taken from pc[INDEX_W+2 +: TAG_W].
- GHR_W, 6, global history length; used only with BP_GSHARE_EN; must be ≤ INDEX_W.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- stall_f_i  in  1  Fetch stalled
- stall_d_i  in  1  Decode stalled (load-use or branch operand stall)
- flush_d_i  in  1  Decode flushed (mispredict or JR)
- pc_f_i  in  32  fetch PC
- predict_taken_f_o  out  1  predicted taken for pc_f_i
- predict_pc_f_o  out  32  predicted next PC
- branch_d_i  in  1  Decode instruction is a conditional branch (any branch_d bit set)
- pc_d_i  in  32  PC of the Decode instruction
- taken_d_i  in  1  actual branch outcome (pc_src_d)
- target_d_i  in  32  actual branch target
- predict_miss_o  out  1  Decode branch was mispredicted
- recover_pc_o  out  32  correct next PC on a miss

Behaviour:
- Reset (async, rst_ni=0):
  - all BTB valid bits = 0; all counters = 2'b01 (weakly not-taken).
  - F→D prediction register cleared: pred_taken_d=0, pred_pc_d=0.
  - GHR=0.
  - Consequences: predict_taken_f_o=0, predict_pc_f_o=pc_f_i+4, predict_miss_o=0.
  - Reset mid-operation discards all table contents.
- Lookup (combinational, zero latency):
  - idx = pc_f_i[INDEX_W+1:2].
  - hit = valid[idx] && tag[idx]==pc_f_i tag field.
  - predict_taken_f_o = hit && ctr[idx][1].
  - predict_pc_f_o = predict_taken_f_o ? target[idx] : pc_f_i+4.
- F→D register (pred_taken_d, pred_pc_d, lookup idx):
  - flush_d_i=1 → cleared (flush wins over stall).
  - else stall_d_i=1 → hold.
  - else → load the Fetch values.
- Resolve (combinational):
  - res = branch_d_i && !stall_d_i.
  - mismatch = (taken_d_i != pred_taken_d) || (taken_d_i && target_d_i != pred_pc_d).
  - predict_miss_o = res && mismatch.
  - recover_pc_o = taken_d_i ? target_d_i : pc_d_i+4; driven always, meaningful only when predict_miss_o=1.
  - While stall_d_i=1: no miss is signalled and no training occurs.
- Training (posedge, when res=1):
  - Counter at the registered index: taken → increment, saturating at 11; not taken → decrement, saturating at 00.
  - Taken: BTB[pc_d idx] gets valid=1, tag, target=target_d_i.
  - Not taken: BTB entry is left unchanged.
  - A different tag overwrites the entry; its counter is not reset.
- Simultaneous lookup and update of the same index: lookup returns the pre-update contents; no write-through bypass.
- Non-branch instructions in Decode: predict_miss_o=0, no training.
- Aliasing on a tag collision is permitted; the resulting mispredictions are corrected by the miss path.

Optional Feature:
- Macro BP_GSHARE_EN.
- Defined:
  - counter index = pc_f_i[INDEX_W+1:2] XOR {zero-extend GHR}.
  - GHR shifts in taken_d_i on every res, LSB-first.
  - The counter index is carried through the F→D register so training hits the entry used for the prediction.
  - The BTB stays PC-indexed.
- Undefined: no GHR; counters use the PC index; GHR_W is unused.

Decomposition:
- Package bp_pkg:
  - typedef enum logic[1:0] bp_ctr_e {STRONG_NT=2'b00, WEAK_NT, WEAK_T, STRONG_T}.
  - function bp_ctr_next(ctr, taken) implementing saturation.
  - struct bp_btb_entry_t {valid, tag, target}.
  - constant CTR_RESET = WEAK_NT.
- One sub-module, branch_target_buffer: the tag/target/valid array with a combinational read port and a clocked write port.
- Counters, GHR and the resolve logic live in the top module.

Test Plan:
- Reset then pc_f_i=0x0040_0010 → predict_taken_f_o=0, predict_pc_f_o=0x0040_0014; predict_miss_o=0.
- Cold branch at pc=0x100, taken to 0x200 → predict_miss_o=1, recover_pc_o=0x200. The next fetch of 0x100 predicts taken with target 0x200 (counter 01→10).
- Same branch resolved taken three times, then not-taken once → counter saturates at 11, then 10; the following fetch still predicts taken; predict_miss_o=1 with recover_pc_o=0x104 on the not-taken resolution.
- Branch in Decode with stall_d_i=1 for 2 cycles and a mismatching outcome → predict_miss_o=0 and no table change during the stall; miss asserted in the first cycle after stall_d_i falls.
- flush_d_i=1 and stall_d_i=1 in the same cycle while holding pred_taken_d=1 → register cleared; a non-branch next cycle gives no miss.
- BP_GSHARE_EN: alternating T/NT branch at 0x300 → after warm-up (≤8 resolutions), zero mispredictions over the next 16 resolutions.

Source files
------------

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types, counter reset value and saturation helper for branch_predict_unit
package bp_pkg;

  localparam int BP_TAG_W = 8;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bp_ctr_e;

  localparam bp_ctr_e CTR_RESET = WEAK_NT;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [31:0]         target;
  } bp_btb_entry_t;

  function automatic bp_ctr_e bp_ctr_next(input bp_ctr_e ctr, input logic taken);
    logic [1:0] raw;
    raw = ctr;
    if (taken && raw != 2'b11) begin
      raw = raw + 2'd1;
    end else if (!taken && raw != 2'b00) begin
      raw = raw - 2'd1;
    end
    return bp_ctr_e'(raw);
  endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - tag/target/valid array, combinational read, clocked write
module branch_target_buffer
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  localparam int INDEX_W = $clog2(ENTRIES)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [INDEX_W-1:0]  rd_idx_i,
  output bp_btb_entry_t       rd_entry_o,
  input  logic                wr_en_i,
  input  logic [INDEX_W-1:0]  wr_idx_i,
  input  logic [BP_TAG_W-1:0] wr_tag_i,
  input  logic [31:0]         wr_target_i
);

  bp_btb_entry_t mem [ENTRIES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem[wr_idx_i] <= '{valid: 1'b1, tag: wr_tag_i, target: wr_target_i};
    end
  end

  // Reads see pre-write contents; a same-cycle update is not bypassed.
  assign rd_entry_o = mem[rd_idx_i];

endmodule

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - BTB + 2-bit counter branch predictor; BP_GSHARE_EN selects gshare counter indexing
module branch_predict_unit
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = BP_TAG_W,
  parameter int GHR_W   = 6
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_f_i,
  input  logic        stall_d_i,
  input  logic        flush_d_i,
  input  logic [31:0] pc_f_i,
  output logic        predict_taken_f_o,
  output logic [31:0] predict_pc_f_o,
  input  logic        branch_d_i,
  input  logic [31:0] pc_d_i,
  input  logic        taken_d_i,
  input  logic [31:0] target_d_i,
  output logic        predict_miss_o,
  output logic [31:0] recover_pc_o
);

  localparam int INDEX_W = $clog2(ENTRIES);

  logic [INDEX_W-1:0] idx_f;
  logic [INDEX_W-1:0] idx_d;
  logic [INDEX_W-1:0] ctr_idx_f;
  logic [INDEX_W-1:0] ctr_idx_d;
  logic               pred_taken_d;
  logic [31:0]        pred_pc_d;
  logic               hit_f;
  logic               res;
  logic               mismatch;
  bp_btb_entry_t      btb_rd;
  bp_ctr_e            ctr [ENTRIES];
  logic               unused_ok;

  assign idx_f = pc_f_i[INDEX_W+1:2];
  assign idx_d = pc_d_i[INDEX_W+1:2];

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] ghr;

  assign ctr_idx_f = idx_f ^ INDEX_W'(ghr);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ghr <= '0;
    end else if (res) begin
      ghr <= {ghr[GHR_W-2:0], taken_d_i};
    end
  end
`else
  logic [GHR_W-1:0] unused_ghr;

  assign unused_ghr = '0;
  assign ctr_idx_f  = idx_f;
`endif

  branch_target_buffer #(.ENTRIES(ENTRIES)) u_btb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rd_idx_i    (idx_f),
    .rd_entry_o  (btb_rd),
    .wr_en_i     (res && taken_d_i),
    .wr_idx_i    (idx_d),
    .wr_tag_i    (pc_d_i[INDEX_W+2 +: TAG_W]),
    .wr_target_i (target_d_i)
  );

  assign hit_f             = btb_rd.valid && (btb_rd.tag == pc_f_i[INDEX_W+2 +: TAG_W]);
  assign predict_taken_f_o = hit_f && ctr[ctr_idx_f][1];
  assign predict_pc_f_o    = predict_taken_f_o ? btb_rd.target : pc_f_i + 32'd4;

  // Flush beats stall so a squashed prediction can never resolve later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pred_taken_d <= 1'b0;
      pred_pc_d    <= '0;
      ctr_idx_d    <= '0;
    end else if (flush_d_i) begin
      pred_taken_d <= 1'b0;
      pred_pc_d    <= '0;
      ctr_idx_d    <= '0;
    end else if (!stall_d_i) begin
      pred_taken_d <= predict_taken_f_o;
      pred_pc_d    <= predict_pc_f_o;
      ctr_idx_d    <= ctr_idx_f;
    end
  end

  assign res            = branch_d_i && !stall_d_i;
  assign mismatch       = (taken_d_i != pred_taken_d) || (taken_d_i && target_d_i != pred_pc_d);
  assign predict_miss_o = res && mismatch;
  assign recover_pc_o   = taken_d_i ? target_d_i : pc_d_i + 32'd4;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i] <= CTR_RESET;
      end
    end else if (res) begin
      ctr[ctr_idx_d] <= bp_ctr_next(ctr[ctr_idx_d], taken_d_i);
    end
  end

  // Fetch stall needs no handling here: lookup is purely combinational on pc_f_i.
  assign unused_ok = stall_f_i;

endmodule
